// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer logic.
// Gray conversions operate on zero-extended values up to GRAY_MAX_W bits, so any narrower width is exact.
package fifo_pkg;

    localparam int unsigned GRAY_MAX_W = 17;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned depth_of(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into the local clock domain.
module sync_nff #(
    parameter int unsigned width  = 1,
    parameter int unsigned stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i_d,
    output logic [width-1:0] o_q
);

    logic [stages-1:0][width-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int s = 1; s < stages; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign o_q = r_sync[stages-1];

endmodule

// File: rtl/wr_ptr_full_unit.sv
// Write-side pointer, Gray export, full/almost-full/level flags and sticky overflow.
// All flags are computed from the next counter value so they land on the same edge as the write.
module wr_ptr_full_unit
    import fifo_pkg::*;
#(
    parameter int unsigned stk_ptr_width      = 3,
    parameter int unsigned almost_full_thresh = 1,
    parameter int unsigned sync_stages        = 2
) (
    input  logic                     clk_write,
    input  logic                     rst,
    input  logic                     write_to_stk,
    input  logic [stk_ptr_width:0]   rd_ptr_gray,
    input  logic                     ovf_clr,
    output logic [stk_ptr_width:0]   wr_cntr,
    output logic [stk_ptr_width-1:0] write_ptr,
    output logic [stk_ptr_width:0]   wr_ptr_gray,
    output logic                     wr_en,
    output logic                     stk_full,
    output logic                     stk_almost_full,
    output logic [stk_ptr_width:0]   wr_level,
    output logic                     overflow
);

    localparam int unsigned CW    = stk_ptr_width + 1;
    localparam int unsigned DEPTH = depth_of(stk_ptr_width);

    logic [CW-1:0] r_wr_cntr;
    logic [CW-1:0] r_wr_gray;
    logic          r_full;
    logic          r_almost_full;
    logic [CW-1:0] r_wr_level;
    logic          r_overflow;

    logic [CW-1:0] w_rd_gray_s;
    logic [CW-1:0] w_rd_bin_s;
    logic [CW-1:0] w_wr_cntr_next;
    logic [CW-1:0] w_wr_gray_next;
    logic [CW-1:0] w_full_pattern;
    logic [CW-1:0] w_wr_level_next;
    logic          w_full_next;
    logic          w_almost_full_next;
    logic          w_overflow_next;

    sync_nff #(
        .width  (CW),
        .stages (sync_stages)
    ) u_rd_sync (
        .clk (clk_write),
        .rst (rst),
        .i_d (rd_ptr_gray),
        .o_q (w_rd_gray_s)
    );

    assign w_rd_bin_s = CW'(gray2bin(GRAY_MAX_W'(w_rd_gray_s)));

    assign wr_en          = write_to_stk & ~r_full;
    assign w_wr_cntr_next = r_wr_cntr + CW'(wr_en);
    assign w_wr_gray_next = CW'(bin2gray(GRAY_MAX_W'(w_wr_cntr_next)));

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign w_full_pattern     = {~w_rd_gray_s[CW-1:CW-2], w_rd_gray_s[CW-3:0]};
    assign w_full_next        = (w_wr_gray_next == w_full_pattern);
    assign w_wr_level_next    = w_wr_cntr_next - w_rd_bin_s;
    assign w_almost_full_next = (32'(DEPTH) - 32'(w_wr_level_next)) <= 32'(almost_full_thresh);
    assign w_overflow_next    = (write_to_stk & r_full) | (r_overflow & ~ovf_clr);

    always_ff @(posedge clk_write or posedge rst) begin
        if (rst) begin
            r_wr_cntr     <= '0;
            r_wr_gray     <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_level    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_wr_cntr     <= w_wr_cntr_next;
            r_wr_gray     <= w_wr_gray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_almost_full_next;
            r_wr_level    <= w_wr_level_next;
            r_overflow    <= w_overflow_next;
        end
    end

    assign wr_cntr         = r_wr_cntr;
    assign write_ptr       = r_wr_cntr[stk_ptr_width-1:0];
    assign wr_ptr_gray     = r_wr_gray;
    assign stk_full        = r_full;
    assign stk_almost_full = r_almost_full;
    assign wr_level        = r_wr_level;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_wr_ptr_full_unit.sv
// Directed bench for wr_ptr_full_unit: default instance plus a wider, deeper-synchronizer instance.
module tb_wr_ptr_full_unit;

    logic clk_write = 1'b0;
    logic rst;

    logic       w0, clr0;
    logic [3:0] rd0;
    logic [3:0] cntr0, gray0, lvl0;
    logic [2:0] wptr0;
    logic       en0, full0, afull0, ovf0;

    logic       w1, clr1;
    logic [4:0] rd1;
    logic [4:0] cntr1, gray1, lvl1;
    logic [3:0] wptr1;
    logic       en1, full1, afull1, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk_write = ~clk_write;

    wr_ptr_full_unit #(
        .stk_ptr_width(3), .almost_full_thresh(1), .sync_stages(2)
    ) dut0 (
        .clk_write(clk_write), .rst(rst), .write_to_stk(w0), .rd_ptr_gray(rd0),
        .ovf_clr(clr0), .wr_cntr(cntr0), .write_ptr(wptr0), .wr_ptr_gray(gray0),
        .wr_en(en0), .stk_full(full0), .stk_almost_full(afull0), .wr_level(lvl0),
        .overflow(ovf0)
    );

    wr_ptr_full_unit #(
        .stk_ptr_width(4), .almost_full_thresh(3), .sync_stages(3)
    ) dut1 (
        .clk_write(clk_write), .rst(rst), .write_to_stk(w1), .rd_ptr_gray(rd1),
        .ovf_clr(clr1), .wr_cntr(cntr1), .write_ptr(wptr1), .wr_ptr_gray(gray1),
        .wr_en(en1), .stk_full(full1), .stk_almost_full(afull1), .wr_level(lvl1),
        .overflow(ovf1)
    );

    task automatic step;
        @(posedge clk_write);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; w0 = 0; clr0 = 0; rd0 = '0; w1 = 0; clr1 = 0; rd1 = '0;
        step(); step();
        rst = 1'b0; w0 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (cntr0 !== 4'd5) begin errors++; $display("FAIL reset_prewrites: wr_cntr=%0d expected 5", cntr0); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cntr0 !== 4'd0 || wptr0 !== 3'd0) begin errors++; $display("FAIL reset_cntr: wr_cntr=%0d write_ptr=%0d expected 0", cntr0, wptr0); end
        checks++;
        if (gray0 !== 4'd0 || lvl0 !== 4'd0) begin errors++; $display("FAIL reset_gray_level: gray=%b level=%0d expected 0", gray0, lvl0); end
        checks++;
        if (full0 !== 1'b0 || afull0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL reset_flags: full=%b afull=%b ovf=%b expected 0", full0, afull0, ovf0); end
        checks++;
        if (cntr1 !== 5'd0 || lvl1 !== 5'd0 || full1 !== 1'b0) begin errors++; $display("FAIL reset_dut1: cntr=%0d level=%0d full=%b expected 0", cntr1, lvl1, full1); end
        w0 = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_fill;
        rd0 = 4'd0; w0 = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (lvl0 !== 4'd6 || afull0 !== 1'b0) begin errors++; $display("FAIL fill_w6: level=%0d afull=%b expected 6/0", lvl0, afull0); end
        step();
        checks++;
        if (lvl0 !== 4'd7 || afull0 !== 1'b1 || full0 !== 1'b0) begin errors++; $display("FAIL fill_w7: level=%0d afull=%b full=%b expected 7/1/0", lvl0, afull0, full0); end
        step();
        checks++;
        if (full0 !== 1'b1 || cntr0 !== 4'd8 || gray0 !== 4'b1100) begin errors++; $display("FAIL fill_w8: full=%b cntr=%0d gray=%b expected 1/8/1100", full0, cntr0, gray0); end
        checks++;
        if (lvl0 !== 4'd8 || wptr0 !== 3'd0) begin errors++; $display("FAIL fill_level8: level=%0d wptr=%0d expected 8/0", lvl0, wptr0); end
        w0 = 1'b0;
    endtask

    task automatic test_write_while_full;
        w0 = 1'b1;
        #1;
        checks++;
        if (en0 !== 1'b0) begin errors++; $display("FAIL full_wr_en: wr_en=%b expected 0", en0); end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (cntr0 !== 4'd8 || ovf0 !== 1'b1) begin errors++; $display("FAIL full_hold: cntr=%0d ovf=%b expected 8/1", cntr0, ovf0); end
        clr0 = 1'b1;
        step();
        checks++;
        if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: ovf=%b expected 1", ovf0); end
        w0 = 1'b0;
        step();
        checks++;
        if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_clear: ovf=%b expected 0", ovf0); end
        clr0 = 1'b0;
    endtask

    task automatic test_read_release;
        rd0 = 4'b0001;
        step();
        checks++;
        if (full0 !== 1'b1 || lvl0 !== 4'd8) begin errors++; $display("FAIL rel_j: full=%b level=%0d expected 1/8", full0, lvl0); end
        step();
        checks++;
        if (full0 !== 1'b1 || lvl0 !== 4'd8) begin errors++; $display("FAIL rel_j1: full=%b level=%0d expected 1/8", full0, lvl0); end
        step();
        checks++;
        if (full0 !== 1'b0 || lvl0 !== 4'd7 || afull0 !== 1'b1) begin errors++; $display("FAIL rel_j2: full=%b level=%0d afull=%b expected 0/7/1", full0, lvl0, afull0); end
    endtask

    task automatic test_wrap;
        logic [3:0] exp_cntr;
        logic [3:0] exp_gray;
        rd0 = 4'b1100;
        step(); step(); step();
        checks++;
        if (lvl0 !== 4'd0 || afull0 !== 1'b0) begin errors++; $display("FAIL wrap_drain: level=%0d afull=%b expected 0/0", lvl0, afull0); end
        exp_cntr = 4'd8;
        w0 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rd0 = exp_cntr ^ (exp_cntr >> 1);
            step();
            exp_cntr = exp_cntr + 4'd1;
            exp_gray = exp_cntr ^ (exp_cntr >> 1);
            checks++;
            if (cntr0 !== exp_cntr || gray0 !== exp_gray || full0 !== 1'b0) begin
                errors++;
                $display("FAIL wrap_%0d: cntr=%0d gray=%b full=%b expected %0d/%b/0", i, cntr0, gray0, full0, exp_cntr, exp_gray);
            end
        end
        w0 = 1'b0;
    endtask

    task automatic test_param_sweep;
        rd1 = 5'd0; w1 = 1'b1;
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (lvl1 !== 5'd12 || afull1 !== 1'b0) begin errors++; $display("FAIL sweep_w12: level=%0d afull=%b expected 12/0", lvl1, afull1); end
        step();
        checks++;
        if (lvl1 !== 5'd13 || afull1 !== 1'b1) begin errors++; $display("FAIL sweep_w13: level=%0d afull=%b expected 13/1", lvl1, afull1); end
        step(); step();
        checks++;
        if (full1 !== 1'b0 || lvl1 !== 5'd15) begin errors++; $display("FAIL sweep_w15: full=%b level=%0d expected 0/15", full1, lvl1); end
        step();
        checks++;
        if (full1 !== 1'b1 || lvl1 !== 5'd16 || gray1 !== 5'b11000) begin errors++; $display("FAIL sweep_w16: full=%b level=%0d gray=%b expected 1/16/11000", full1, lvl1, gray1); end
        w1 = 1'b0;
        rd1 = 5'b00001;
        step(); step(); step();
        checks++;
        if (full1 !== 1'b1) begin errors++; $display("FAIL sweep_rel_j2: full=%b expected 1", full1); end
        step();
        checks++;
        if (full1 !== 1'b0 || lvl1 !== 5'd15) begin errors++; $display("FAIL sweep_rel_j3: full=%b level=%0d expected 0/15", full1, lvl1); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_while_full();
        test_read_release();
        test_wrap();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wr_ptr_full_unit.md
# wr_ptr_full_unit

Write-side pointer and full-flag generator for the dual-clock stack/FIFO, clocked entirely by `clk_write`. It extends a plain free-running write counter with several features:
- write acceptance gating;
- a Gray-coded pointer exported to the read domain;
- an internal synchronizer for the read domain's Gray pointer;
- registered full, almost-full and fill-level outputs;
- a sticky overflow flag.

It sits between the write-side user logic and the dual-port memory write port.

## Interface
- `stk_ptr_width`, 3: address bits. Depth = 2^stk_ptr_width. Legal range 2..16.
- `almost_full_thresh`, 1: `stk_almost_full` asserts when free slots ≤ this value. Legal range 0..depth-1.
- `sync_stages`, 2: flop stages on the incoming read pointer. Legal range 2..4.

Ports:
- `clk_write`  in  1  write-domain clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state including synchronizer flops.
- `write_to_stk`  in  1  write request.
- `rd_ptr_gray`  in  stk_ptr_width+1  Gray read pointer from the read domain; asynchronous to `clk_write`.
- `ovf_clr`  in  1  clears the sticky overflow flag.
- `wr_cntr`  out  stk_ptr_width+1  binary write counter, including the wrap bit.
- `write_ptr`  out  stk_ptr_width  memory write address, equal to `wr_cntr[stk_ptr_width-1:0]`.
- `wr_ptr_gray`  out  stk_ptr_width+1  registered Gray form of `wr_cntr`, for the read-domain synchronizer.
- `wr_en`  out  1  combinational: `write_to_stk & ~stk_full`; drives the memory write enable.
- `stk_full`  out  1  registered full flag.
- `stk_almost_full`  out  1  registered almost-full flag.
- `wr_level`  out  stk_ptr_width+1  registered occupancy as seen from the write side.
- `overflow`  out  1  sticky flag: a write was attempted while full.

## Operation
- Reset (asynchronous): all outputs and internal flops go to 0. Reset can assert mid-operation at any point; state is lost and there is no recovery of the pointer.
- Accept rule: a write is accepted at an edge when `wr_en`=1. On acceptance, `wr_cntr` increments modulo 2^(stk_ptr_width+1). Otherwise `wr_cntr` holds.
- `wr_ptr_gray` is registered from `bin2gray(wr_cntr_next)`, so it always equals `bin2gray(wr_cntr)` and is glitch-free.
- Synchronizer: `rd_ptr_gray` passes through `sync_stages` flops to give `rd_gray_s`. `rd_bin_s` is `gray2bin(rd_gray_s)`.
- Full: `stk_full_next` is set when `bin2gray(wr_cntr_next)` equals `rd_gray_s` with its two MSBs inverted and all other bits equal.
- Level: `wr_level_next = wr_cntr_next - rd_bin_s`, computed modulo 2^(stk_ptr_width+1); the result is ≤ depth.
- Almost-full: `stk_almost_full_next` = (depth - `wr_level_next`) ≤ `almost_full_thresh`.
- Overflow: set when `write_to_stk`=1 and `stk_full`=1. Cleared by `ovf_clr`. If set and clear occur at the same edge, set wins.
- Full is pessimistic: the read pointer is stale by the synchronizer latency, so full may stay asserted after reads. This is never unsafe.
- Wrap-around: `wr_cntr` rolls over from 2^(stk_ptr_width+1)-1 to 0, and `wr_ptr_gray` rolls over to 0. The comparison logic is unaffected by the rollover.

## Timing
- Accepted write at edge k: `wr_cntr`, `write_ptr`, `wr_ptr_gray`, `wr_level`, `stk_full` and `stk_almost_full` all reflect it after edge k. The flags have zero added latency relative to the counter.
- A change on `rd_ptr_gray` that is stable before edge j appears in `rd_gray_s` after edge j+sync_stages-1. It appears in `stk_full` and `wr_level` after edge j+sync_stages.
- `wr_en` is combinational from `write_to_stk` and `stk_full`, with no added latency.
- First write after reset release is accepted at the first edge.

## Structure
- Shared package `fifo_pkg` holds:
  - functions `bin2gray` and `gray2bin`, parameterised by width;
  - constant helper `depth_of(width)`.
- One sub-module, `sync_nff`, parameterised by width and stages, with asynchronous active-high reset. It is instantiated for `rd_ptr_gray`.
- The read-side counterpart reuses both the package and `sync_nff`.

## Test plan
- Reset values: assert `rst` mid-stream after 5 writes. All outputs are immediately 0, including `overflow`, `wr_level` and `wr_ptr_gray`.
- Fill to full (defaults): hold `rd_ptr_gray`=0 and issue 8 consecutive writes.
  - After write 7: `stk_almost_full`=1, `wr_level`=7.
  - After write 8: `stk_full`=1, `wr_cntr`=8, `wr_ptr_gray`=4'b1100.
- Write while full: with the state from the previous test, apply `write_to_stk`=1 for 3 cycles.
  - `wr_en`=0, `wr_cntr` stays 8, `overflow`=1.
  - Pulse `ovf_clr` together with another write while still full: `overflow` stays 1.
  - Pulse `ovf_clr` alone: `overflow` returns to 0.
- Read release: from full, drive `rd_ptr_gray`=4'b0001 (rd=1) before edge j.
  - `stk_full` stays 1 through edge j+1 and is 0 after edge j+2.
  - `wr_level` goes from 8 to 7 at the same edge.
- Wrap-around: advance `rd_ptr_gray` in step so the FIFO never fills, and issue 17 writes.
  - `wr_cntr` goes 15→0→1.
  - `wr_ptr_gray` goes 4'b1000→4'b0000→4'b0001.
  - `stk_full` never asserts.
- Parameter sweep: `stk_ptr_width`=4, `almost_full_thresh`=3, `sync_stages`=3.
  - Almost-full asserts at `wr_level`=13.
  - Full asserts at 16.
  - Full-release latency is 3 edges.
